regfile_wb_arbiter: RTL and testbench

- Shares the single write port of the 32x32 register file among NREQ writeback requesters, such as the ALU result and the load-data return.
- Each cycle it picks at most one requester by round-robin and accepts its write.
- The accepted write is registered and presented as write data plus a one-hot 32-bit write-enable vector that drives the register file's D/En inputs directly.
- Writes to register 0 are accepted but suppressed, so r0 stays hardwired to zero.

---
 rtl/regfile_wb_arbiter_pkg.sv | 13 +
 rtl/regfile_wb_arbiter_if.sv | 38 +++
 rtl/regfile_wb_arbiter_rr_arbiter.sv | 40 ++++
 rtl/regfile_wb_arbiter.sv | 72 +++++++
 tb/tb_regfile_wb_arbiter.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared register-file constants and the one-hot write-enable decode.
package regfile_pkg;
  localparam int REG_AW = 5;
  localparam int REG_DW = 32;
  localparam int REG_N  = 32;
  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  // r0 is hardwired to zero, so its enable bit is never produced.
  function automatic logic [REG_N-1:0] onehot_dec(input logic [REG_AW-1:0] a);
    onehot_dec = '0;
    if (a != REG_ZERO) onehot_dec[a] = 1'b1;
  endfunction
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between requesters and the register-file write port.
// Optional forwarding signals exist only when REGFILE_WB_FWD_EN is defined.
interface regfile_wb_arbiter_if #(
  parameter int NREQ = 2,
  parameter int AW   = 5,
  parameter int DW   = 32
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Handshake: requester i transfers in any cycle where Req[i] && Gnt[i];
  // Req, Addr and Wdata for i stay stable until that cycle.
  logic               Stall;
  logic [NREQ-1:0]    Req;
  logic [NREQ*AW-1:0] Addr;
  logic [NREQ*DW-1:0] Wdata;
  logic [NREQ-1:0]    Gnt;
  logic [DW-1:0]      D;
  logic [2**AW-1:0]   En;
  logic               Busy;
  logic [IW-1:0]      rr;
`ifdef REGFILE_WB_FWD_EN
  logic [AW-1:0]      RaddrA;
  logic [AW-1:0]      RaddrB;
  logic               FwdHitA;
  logic               FwdHitB;
  logic [DW-1:0]      FwdData;

  modport master (output Stall, Req, Addr, Wdata, RaddrA, RaddrB,
                  input Gnt, D, En, Busy, rr, FwdHitA, FwdHitB, FwdData);
  modport slave  (input Stall, Req, Addr, Wdata, RaddrA, RaddrB,
                  output Gnt, D, En, Busy, rr, FwdHitA, FwdHitB, FwdData);
`else
  modport master (output Stall, Req, Addr, Wdata,
                  input Gnt, D, En, Busy, rr);
  modport slave  (input Stall, Req, Addr, Wdata,
                  output Gnt, D, En, Busy, rr);
`endif
endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Generic NREQ-wide round-robin arbiter; the search starts at rr and wraps.
module rr_arbiter #(
  parameter int NREQ = 2,
  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            Clk,
  input  logic            Clr,
  input  logic            Stall,
  input  logic [NREQ-1:0] Req,
  output logic [NREQ-1:0] Gnt,
  output logic [IW-1:0]   gnt_idx,
  output logic            gnt_valid,
  output logic [IW-1:0]   rr
);
  int j;

  // Gnt is forced low while Clr is held so nothing is consumed during reset.
  always_comb begin
    Gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    j         = 0;
    if (!Stall && !Clr) begin
      for (int k = 0; k < NREQ; k++) begin
        j = int'(rr) + k;
        if (j >= NREQ) j = j - NREQ;
        if (!gnt_valid && Req[j]) begin
          Gnt[j]    = 1'b1;
          gnt_idx   = IW'(j);
          gnt_valid = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) rr <= '0;
    else if (gnt_valid) rr <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter for the 32x32 register file write port.
// Build macro REGFILE_WB_FWD_EN adds read-address forwarding outputs.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int AW   = REG_AW,
  parameter int DW   = REG_DW
) (
  input logic Clk,
  input logic Clr,
  regfile_wb_arbiter_if.slave bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int NE = 2**AW;

  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   gnt_idx;
  logic [IW-1:0]   rr;
  logic            gnt_valid;
  logic [AW-1:0]   addr_g;
  logic [DW-1:0]   wdata_g;
  logic [NE-1:0]   en_next;
  logic [DW-1:0]   d_q;
  logic [NE-1:0]   en_q;
  logic            busy_q;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .Clk       (Clk),
    .Clr       (Clr),
    .Stall     (bus.Stall),
    .Req       (bus.Req),
    .Gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .rr        (rr)
  );

  assign addr_g  = bus.Addr[gnt_idx*AW +: AW];
  assign wdata_g = bus.Wdata[gnt_idx*DW +: DW];
  assign en_next = NE'(onehot_dec(REG_AW'(addr_g)));

  // D holds across idle cycles; only En is cleared when nothing is granted.
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      d_q    <= '0;
      en_q   <= '0;
      busy_q <= 1'b0;
    end else begin
      busy_q <= |(bus.Req & ~gnt);
      if (gnt_valid) begin
        d_q  <= wdata_g;
        en_q <= en_next;
      end else begin
        en_q <= '0;
      end
    end
  end

  assign bus.Gnt  = gnt;
  assign bus.D    = d_q;
  assign bus.En   = en_q;
  assign bus.Busy = busy_q;
  assign bus.rr   = rr;

`ifdef REGFILE_WB_FWD_EN
  // En is one-hot, so testing the addressed bit identifies the pending write.
  assign bus.FwdHitA = (en_q != '0) && en_q[bus.RaddrA];
  assign bus.FwdHitB = (en_q != '0) && en_q[bus.RaddrB];
  assign bus.FwdData = d_q;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a small register-file model.
module tb_regfile_wb_arbiter;
  logic Clk;
  logic Clr;
  int   n_cmp;
  int   n_err;
  logic [31:0] rf [32];

  regfile_wb_arbiter_if #(.NREQ(2), .AW(5), .DW(32)) bus ();

  regfile_wb_arbiter #(.NREQ(2), .AW(5), .DW(32)) dut (
    .Clk (Clk),
    .Clr (Clr),
    .bus (bus)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

  // register file model capturing D/En at each rising edge
  always @(posedge Clk) begin
    if (Clr) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      for (int i = 0; i < 32; i++) if (bus.En[i]) rf[i] <= bus.D;
    end
  end

  // driver tasks
  task automatic drive(input logic [1:0] req, input logic [4:0] a0, input logic [4:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1, input logic stall);
    @(negedge Clk);
    bus.Req   = req;
    bus.Addr  = {a1, a0};
    bus.Wdata = {d1, d0};
    bus.Stall = stall;
    #1;
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset;
    Clr = 1'b1;
    drive(2'b11, 5'd1, 5'd2, 32'h1, 32'h2, 1'b0);
    n_cmp++; if (bus.Gnt !== 2'b00) begin n_err++; $display("FAIL reset_gnt got=%b exp=00", bus.Gnt); end
    tick;
    n_cmp++; if (bus.D !== 32'h0) begin n_err++; $display("FAIL reset_d got=%h exp=0", bus.D); end
    n_cmp++; if (bus.En !== 32'h0) begin n_err++; $display("FAIL reset_en got=%h exp=0", bus.En); end
    n_cmp++; if (bus.Busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", bus.Busy); end
    n_cmp++; if (bus.rr !== 1'b0) begin n_err++; $display("FAIL reset_rr got=%b exp=0", bus.rr); end
    drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
    Clr = 1'b0;
    tick;
  endtask

  task automatic test_single;
    drive(2'b01, 5'd5, 5'd0, 32'hF0F0F0F0, 32'h0, 1'b0);
    n_cmp++; if (bus.Gnt !== 2'b01) begin n_err++; $display("FAIL single_gnt got=%b exp=01", bus.Gnt); end
    tick;
    n_cmp++; if (bus.En !== 32'h00000020) begin n_err++; $display("FAIL single_en got=%h exp=00000020", bus.En); end
    n_cmp++; if (bus.D !== 32'hF0F0F0F0) begin n_err++; $display("FAIL single_d got=%h exp=f0f0f0f0", bus.D); end
    n_cmp++; if (bus.Busy !== 1'b0) begin n_err++; $display("FAIL single_busy got=%b exp=0", bus.Busy); end
    n_cmp++; if (bus.rr !== 1'b1) begin n_err++; $display("FAIL single_rr got=%b exp=1", bus.rr); end
    drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
    tick;
    n_cmp++; if (bus.En !== 32'h0) begin n_err++; $display("FAIL single_idle_en got=%h exp=0", bus.En); end
    n_cmp++; if (bus.D !== 32'hF0F0F0F0) begin n_err++; $display("FAIL single_hold_d got=%h exp=f0f0f0f0", bus.D); end
    n_cmp++; if (rf[5] !== 32'hF0F0F0F0) begin n_err++; $display("FAIL single_rf5 got=%h exp=f0f0f0f0", rf[5]); end
    n_cmp++; if (bus.rr !== 1'b1) begin n_err++; $display("FAIL single_idle_rr got=%b exp=1", bus.rr); end
  endtask

  task automatic test_alternate;
    logic [1:0]  exp_g;
    logic [31:0] exp_en;
    logic [31:0] exp_d;
    // bring the pointer back to 0 with a lone request from requester 1
    drive(2'b10, 5'd0, 5'd1, 32'h0, 32'h1, 1'b0);
    n_cmp++; if (bus.Gnt !== 2'b10) begin n_err++; $display("FAIL alt_prime_gnt got=%b exp=10", bus.Gnt); end
    tick;
    n_cmp++; if (bus.En !== 32'h2) begin n_err++; $display("FAIL alt_prime_en got=%h exp=2", bus.En); end
    n_cmp++; if (bus.rr !== 1'b0) begin n_err++; $display("FAIL alt_prime_rr got=%b exp=0", bus.rr); end
    for (int i = 0; i < 4; i++) begin
      exp_g  = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_en = (i % 2 == 0) ? 32'h8 : 32'h80;
      exp_d  = (i % 2 == 0) ? 32'hA0A0A0A0 : 32'hA1A1A1A1;
      drive(2'b11, 5'd3, 5'd7, 32'hA0A0A0A0, 32'hA1A1A1A1, 1'b0);
      n_cmp++; if (bus.Gnt !== exp_g) begin n_err++; $display("FAIL alt_gnt[%0d] got=%b exp=%b", i, bus.Gnt, exp_g); end
      tick;
      n_cmp++; if (bus.En !== exp_en) begin n_err++; $display("FAIL alt_en[%0d] got=%h exp=%h", i, bus.En, exp_en); end
      n_cmp++; if (bus.D !== exp_d) begin n_err++; $display("FAIL alt_d[%0d] got=%h exp=%h", i, bus.D, exp_d); end
      n_cmp++; if (bus.Busy !== 1'b1) begin n_err++; $display("FAIL alt_busy[%0d] got=%b exp=1", i, bus.Busy); end
    end
    drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
    tick;
    n_cmp++; if (bus.Busy !== 1'b0) begin n_err++; $display("FAIL alt_idle_busy got=%b exp=0", bus.Busy); end
    n_cmp++; if (bus.rr !== 1'b0) begin n_err++; $display("FAIL alt_end_rr got=%b exp=0", bus.rr); end
  endtask

  task automatic test_r0;
    drive(2'b01, 5'd0, 5'd0, 32'hDEADBEEF, 32'h0, 1'b0);
    n_cmp++; if (bus.Gnt !== 2'b01) begin n_err++; $display("FAIL r0_gnt got=%b exp=01", bus.Gnt); end
    tick;
    n_cmp++; if (bus.En !== 32'h0) begin n_err++; $display("FAIL r0_en got=%h exp=0", bus.En); end
    n_cmp++; if (bus.D !== 32'hDEADBEEF) begin n_err++; $display("FAIL r0_d got=%h exp=deadbeef", bus.D); end
    n_cmp++; if (bus.rr !== 1'b1) begin n_err++; $display("FAIL r0_rr got=%b exp=1", bus.rr); end
    drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
    tick;
    n_cmp++; if (rf[0] !== 32'h0) begin n_err++; $display("FAIL r0_rf0 got=%h exp=0", rf[0]); end
  endtask

  task automatic test_same_addr;
    drive(2'b11, 5'd9, 5'd9, 32'h11, 32'h22, 1'b0);
    n_cmp++; if (bus.Gnt !== 2'b10) begin n_err++; $display("FAIL same_gnt1 got=%b exp=10", bus.Gnt); end
    tick;
    n_cmp++; if (bus.En !== 32'h200) begin n_err++; $display("FAIL same_en1 got=%h exp=200", bus.En); end
    n_cmp++; if (bus.D !== 32'h22) begin n_err++; $display("FAIL same_d1 got=%h exp=22", bus.D); end
    n_cmp++; if (bus.Busy !== 1'b1) begin n_err++; $display("FAIL same_busy1 got=%b exp=1", bus.Busy); end
    drive(2'b01, 5'd9, 5'd9, 32'h11, 32'h22, 1'b0);
    n_cmp++; if (bus.Gnt !== 2'b01) begin n_err++; $display("FAIL same_gnt0 got=%b exp=01", bus.Gnt); end
    tick;
    n_cmp++; if (bus.En !== 32'h200) begin n_err++; $display("FAIL same_en0 got=%h exp=200", bus.En); end
    n_cmp++; if (bus.D !== 32'h11) begin n_err++; $display("FAIL same_d0 got=%h exp=11", bus.D); end
    n_cmp++; if (bus.Busy !== 1'b0) begin n_err++; $display("FAIL same_busy0 got=%b exp=0", bus.Busy); end
    drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
    tick;
    n_cmp++; if (rf[9] !== 32'h11) begin n_err++; $display("FAIL same_rf9 got=%h exp=11", rf[9]); end
  endtask

  task automatic test_stall;
    for (int i = 0; i < 3; i++) begin
      drive(2'b11, 5'd3, 5'd7, 32'h33, 32'h77, 1'b1);
      n_cmp++; if (bus.Gnt !== 2'b00) begin n_err++; $display("FAIL stall_gnt[%0d] got=%b exp=00", i, bus.Gnt); end
      tick;
      n_cmp++; if (bus.En !== 32'h0) begin n_err++; $display("FAIL stall_en[%0d] got=%h exp=0", i, bus.En); end
      n_cmp++; if (bus.Busy !== 1'b1) begin n_err++; $display("FAIL stall_busy[%0d] got=%b exp=1", i, bus.Busy); end
      n_cmp++; if (bus.rr !== 1'b1) begin n_err++; $display("FAIL stall_rr[%0d] got=%b exp=1", i, bus.rr); end
      n_cmp++; if (bus.D !== 32'h11) begin n_err++; $display("FAIL stall_d[%0d] got=%h exp=11", i, bus.D); end
    end
    drive(2'b11, 5'd3, 5'd7, 32'h33, 32'h77, 1'b0);
    n_cmp++; if (bus.Gnt !== 2'b10) begin n_err++; $display("FAIL resume_gnt1 got=%b exp=10", bus.Gnt); end
    tick;
    n_cmp++; if (bus.En !== 32'h80) begin n_err++; $display("FAIL resume_en1 got=%h exp=80", bus.En); end
    n_cmp++; if (bus.D !== 32'h77) begin n_err++; $display("FAIL resume_d1 got=%h exp=77", bus.D); end
    drive(2'b01, 5'd3, 5'd7, 32'h33, 32'h77, 1'b0);
    n_cmp++; if (bus.Gnt !== 2'b01) begin n_err++; $display("FAIL resume_gnt0 got=%b exp=01", bus.Gnt); end
    tick;
    n_cmp++; if (bus.En !== 32'h8) begin n_err++; $display("FAIL resume_en0 got=%h exp=8", bus.En); end
    n_cmp++; if (bus.D !== 32'h33) begin n_err++; $display("FAIL resume_d0 got=%h exp=33", bus.D); end
    drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
    tick;
  endtask

`ifdef REGFILE_WB_FWD_EN
  task automatic test_fwd;
    drive(2'b10, 5'd0, 5'd12, 32'h0, 32'hCAFE0012, 1'b0);
    bus.RaddrA = 5'd12;
    bus.RaddrB = 5'd13;
    n_cmp++; if (bus.Gnt !== 2'b10) begin n_err++; $display("FAIL fwd_gnt got=%b exp=10", bus.Gnt); end
    tick;
    n_cmp++; if (bus.FwdHitA !== 1'b1) begin n_err++; $display("FAIL fwd_hit_a got=%b exp=1", bus.FwdHitA); end
    n_cmp++; if (bus.FwdHitB !== 1'b0) begin n_err++; $display("FAIL fwd_hit_b got=%b exp=0", bus.FwdHitB); end
    n_cmp++; if (bus.FwdData !== 32'hCAFE0012) begin n_err++; $display("FAIL fwd_data got=%h exp=cafe0012", bus.FwdData); end
    drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
    tick;
    n_cmp++; if (bus.FwdHitA !== 1'b0) begin n_err++; $display("FAIL fwd_idle_hit_a got=%b exp=0", bus.FwdHitA); end
  endtask
`endif

  task automatic test_clr_mid;
    drive(2'b01, 5'd3, 5'd7, 32'h5A5A5A5A, 32'h0, 1'b0);
    tick;
    n_cmp++; if (bus.En !== 32'h8) begin n_err++; $display("FAIL clr_pre_en got=%h exp=8", bus.En); end
    Clr = 1'b1;
    #1;
    n_cmp++; if (bus.En !== 32'h0) begin n_err++; $display("FAIL clr_en got=%h exp=0", bus.En); end
    n_cmp++; if (bus.Busy !== 1'b0) begin n_err++; $display("FAIL clr_busy got=%b exp=0", bus.Busy); end
    n_cmp++; if (bus.rr !== 1'b0) begin n_err++; $display("FAIL clr_rr got=%b exp=0", bus.rr); end
    n_cmp++; if (bus.D !== 32'h0) begin n_err++; $display("FAIL clr_d got=%h exp=0", bus.D); end
    n_cmp++; if (bus.Gnt !== 2'b00) begin n_err++; $display("FAIL clr_gnt got=%b exp=00", bus.Gnt); end
    Clr = 1'b0;
    #1;
    n_cmp++; if (bus.Gnt !== 2'b01) begin n_err++; $display("FAIL clr_regnt got=%b exp=01", bus.Gnt); end
    tick;
    n_cmp++; if (bus.En !== 32'h8) begin n_err++; $display("FAIL clr_re_en got=%h exp=8", bus.En); end
    n_cmp++; if (bus.D !== 32'h5A5A5A5A) begin n_err++; $display("FAIL clr_re_d got=%h exp=5a5a5a5a", bus.D); end
    drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
    tick;
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    Clr       = 1'b1;
    bus.Req   = '0;
    bus.Addr  = '0;
    bus.Wdata = '0;
    bus.Stall = 1'b0;
`ifdef REGFILE_WB_FWD_EN
    bus.RaddrA = '0;
    bus.RaddrB = '0;
`endif
    test_reset;
    test_single;
    test_alternate;
    test_r0;
    test_same_addr;
    test_stall;
`ifdef REGFILE_WB_FWD_EN
    test_fwd;
`endif
    test_clr_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
